// File: rtl/qnr_div_pkg.sv
// ============================================================================
// Module  : qnr_div_pkg
// Brief   : Shared defaults, tag type and saturation value for the divider scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

package qnr_div_pkg;

  localparam int QNR_DIV_NREQ = 3;
  localparam int QNR_DIV_DW   = 12;
  localparam int QNR_DIV_QW   = 8;
  localparam int QNR_DIV_IDW  = (QNR_DIV_NREQ > 1) ? $clog2(QNR_DIV_NREQ) : 1;

  localparam logic [QNR_DIV_DW-1:0] QNR_DIV_SAT = {QNR_DIV_DW{1'b1}};

  typedef struct packed {
    logic                   valid;
    logic [QNR_DIV_IDW-1:0] id;
    logic                   dz;
  } qnr_div_tag_t;

endpackage

`default_nettype wire

// File: rtl/qnr_div_rsp_fifo.sv
// ============================================================================
// Module  : qnr_div_rsp_fifo
// Brief   : Per-requester response FIFO, circular buffer with occupancy count.
// Revision: 1.0
// ============================================================================
`default_nettype none

module qnr_div_rsp_fifo
  import qnr_div_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = QNR_DIV_DW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int c_pw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cw = $clog2(DEPTH + 1);

  logic [W-1:0]    mem_q [DEPTH];
  logic [c_pw-1:0] wr_q, wr_d;
  logic [c_pw-1:0] rd_q, rd_d;
  logic [c_cw-1:0] cnt_q, cnt_d;
  logic            do_push, do_pop;

  function automatic logic [c_pw-1:0] ptr_inc(input logic [c_pw-1:0] p);
    return (p == c_pw'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == c_cw'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d  = do_push ? ptr_inc(wr_q) : wr_q;
    rd_d  = do_pop ? ptr_inc(rd_q) : rd_q;
    cnt_d = cnt_q + c_cw'(do_push) - c_cw'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/qnr_div_sched.sv
// ============================================================================
// Module  : qnr_div_sched
// Brief   : Credit-gated round-robin issue scheduler for the shared pipelined divider.
// Revision: 1.0
// ============================================================================
`default_nettype none

module qnr_div_sched
  import qnr_div_pkg::*;
#(
  parameter int NREQ       = QNR_DIV_NREQ,
  parameter int DW         = QNR_DIV_DW,
  parameter int QW         = QNR_DIV_QW,
  parameter int DIV_LAT    = 12,
  parameter int OBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]    req_valid_i,
  output logic [NREQ-1:0]    req_ready_o,
  input  logic [NREQ*DW-1:0] req_dividend_i,
  input  logic [NREQ*QW-1:0] req_divisor_i,
  output logic               div_en_o,
  output logic [DW-1:0]      div_dividend_o,
  output logic [QW-1:0]      div_divisor_o,
  input  logic [DW-1:0]      div_q_i,
  output logic [NREQ-1:0]    rsp_valid_o,
  input  logic [NREQ-1:0]    rsp_ready_i,
  output logic [NREQ*DW-1:0] rsp_q_o,
  output logic               busy_o
);

  localparam int c_cw = $clog2(OBUF_DEPTH + 1);

  logic [c_cw-1:0]        credit_q [NREQ];
  logic [c_cw-1:0]        credit_d [NREQ];
  logic [QNR_DIV_IDW-1:0] last_q, last_d;
  logic [NREQ-1:0]        elig, grant;
  logic                   accept;
  logic [QNR_DIV_IDW-1:0] gid;
  int                     idx;
  logic [DW-1:0]          sel_dividend;
  logic [QW-1:0]          sel_divisor;

  qnr_div_tag_t           tag_q [DIV_LAT+1];
  logic [DW-1:0]          div_dividend_q;
  logic [QW-1:0]          div_divisor_q;

  logic [NREQ-1:0]        retire_hit, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DW-1:0]          push_data;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) elig[i] = req_valid_i[i] && (credit_q[i] != '0);
  end

  always_comb begin
    grant  = '0;
    accept = 1'b0;
    gid    = '0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!accept && elig[idx]) begin
        accept     = 1'b1;
        grant[idx] = 1'b1;
        gid        = QNR_DIV_IDW'(idx);
      end
    end
    if (rst) begin
      grant  = '0;
      accept = 1'b0;
    end
  end

  assign req_ready_o  = grant;
  assign sel_dividend = req_dividend_i[int'(gid)*DW +: DW];
  assign sel_divisor  = req_divisor_i[int'(gid)*QW +: QW];

  always_comb begin
    last_d = accept ? gid : last_q;
    for (int i = 0; i < NREQ; i++)
      credit_d[i] = credit_q[i] + c_cw'(fifo_pop[i]) - c_cw'(grant[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= QNR_DIV_IDW'(NREQ - 1);
      for (int i = 0; i < NREQ; i++) credit_q[i] <= c_cw'(OBUF_DEPTH);
    end else begin
      last_q <= last_d;
      for (int i = 0; i < NREQ; i++) credit_q[i] <= credit_d[i];
    end
  end

  // Stage 0 is the issue register itself; stage DIV_LAT lines up with div_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= DIV_LAT; k++) tag_q[k] <= '0;
      div_dividend_q <= '0;
      div_divisor_q  <= '0;
    end else begin
      tag_q[0] <= '{valid: accept, id: gid, dz: (sel_divisor == '0)};
      for (int k = 1; k <= DIV_LAT; k++) tag_q[k] <= tag_q[k-1];
      if (accept) begin
        div_dividend_q <= sel_dividend;
        div_divisor_q  <= sel_divisor;
      end
    end
  end

  assign div_en_o       = tag_q[0].valid;
  assign div_dividend_o = div_dividend_q;
  assign div_divisor_o  = div_divisor_q;
  assign push_data      = tag_q[DIV_LAT].dz ? {DW{QNR_DIV_SAT[0]}} : div_q_i;

  for (genvar i = 0; i < NREQ; i++) begin : g_rsp
    assign retire_hit[i]  = tag_q[DIV_LAT].valid && (tag_q[DIV_LAT].id == QNR_DIV_IDW'(i));
    assign fifo_push[i]   = retire_hit[i] && !fifo_full[i];
    assign fifo_pop[i]    = rsp_valid_o[i] && rsp_ready_i[i];
    assign rsp_valid_o[i] = !fifo_empty[i];

    qnr_div_rsp_fifo #(
      .DEPTH (OBUF_DEPTH),
      .W     (DW)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push[i]),
      .data_i  (push_data),
      .pop_i   (fifo_pop[i]),
      .data_o  (rsp_q_o[i*DW +: DW]),
      .full_o  (fifo_full[i]),
      .empty_o (fifo_empty[i])
    );
  end

  always_comb begin
    busy_o = !(&fifo_empty);
    for (int k = 0; k <= DIV_LAT; k++) busy_o = busy_o | tag_q[k].valid;
  end

endmodule

`default_nettype wire

// File: tb/tb_qnr_div_sched.sv
// ============================================================================
// Module  : tb_qnr_div_sched
// Brief   : Directed self-checking bench for qnr_div_sched with a pipelined divider model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_qnr_div_sched;

  localparam int NREQ = 3;
  localparam int DW   = 12;
  localparam int QW   = 8;
  localparam int LAT  = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_dividend = '0;
  logic [NREQ*QW-1:0] req_divisor = '0;
  logic               div_en;
  logic [DW-1:0]      div_dividend;
  logic [QW-1:0]      div_divisor;
  logic [DW-1:0]      div_q;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready = '0;
  logic [NREQ*DW-1:0] rsp_q;
  logic               busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qnr_div_sched #(
    .NREQ(NREQ), .DW(DW), .QW(QW), .DIV_LAT(LAT), .OBUF_DEPTH(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_dividend_i (req_dividend),
    .req_divisor_i  (req_divisor),
    .div_en_o       (div_en),
    .div_dividend_o (div_dividend),
    .div_divisor_o  (div_divisor),
    .div_q_i        (div_q),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_q_o        (rsp_q),
    .busy_o         (busy)
  );

  // Divider model: quotient valid LAT cycles after div_en; divide-by-zero yields 0.
  logic [DW-1:0] pipe [1:LAT];
  always @(posedge clk) begin
    if (!div_en)             pipe[1] <= 12'hABC;
    else if (div_divisor == 0) pipe[1] <= 12'h000;
    else                     pipe[1] <= div_dividend / {4'b0, div_divisor};
    for (int k = 2; k <= LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign div_q = pipe[LAT];

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        checks++;
        assert (!(dut.retire_hit[i] && dut.fifo_full[i]) && (dut.credit_q[i] <= 3'd4)) else begin
          errors++;
          $error("FAIL overflow_or_credit req=%0d observed_credit=%0d expected_max=4", i, dut.credit_q[i]);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 3'b111;
    settle();
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_div_en", 32'(div_en), 32'h0);
    chk("rst_div_dividend", 32'(div_dividend), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_credit0", 32'(dut.credit_q[0]), 32'h4);
    cyc();
    rst       = 1'b0;
    req_valid = '0;
  endtask

  logic [DW-1:0] expq [NREQ][$];
  int            acc;
  logic          stale;
  logic [DW-1:0] v;

  initial begin
    cyc();
    do_reset();

    // Single request: requester 1 sends 100/7.
    rsp_ready = 3'b111;
    req_valid = 3'b010;
    req_dividend[1*DW +: DW] = 12'd100;
    req_divisor[1*QW +: QW]  = 8'd7;
    settle();
    chk("single_ready", 32'(req_ready), 32'h2);
    cyc();
    req_valid = '0;
    settle();
    chk("single_div_en", 32'(div_en), 32'h1);
    chk("single_dividend", 32'(div_dividend), 32'd100);
    chk("single_divisor", 32'(div_divisor), 32'd7);
    chk("single_busy", 32'(busy), 32'h1);
    cyc();
    settle();
    chk("single_div_en_low", 32'(div_en), 32'h0);
    cyc(LAT - 1);
    settle();
    chk("single_rsp_early", 32'(rsp_valid), 32'h0);
    cyc();
    settle();
    chk("single_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("single_rsp_q", 32'(rsp_q[1*DW +: DW]), 32'd14);
    chk("single_busy_pop", 32'(busy), 32'h1);
    cyc();
    settle();
    chk("single_rsp_gone", 32'(rsp_valid), 32'h0);
    chk("single_busy_low", 32'(busy), 32'h0);

    // Contention: all valid, grants rotate 0,1,2,...
    cyc();
    do_reset();
    rsp_ready = 3'b111;
    for (int k = 0; k < 6; k++) begin
      req_valid = 3'b111;
      for (int i = 0; i < NREQ; i++) begin
        req_dividend[i*DW +: DW] = 12'(200 + 30*k + i);
        req_divisor[i*QW +: QW]  = 8'(i + 2);
      end
      settle();
      chk($sformatf("cont_grant_%0d", k), 32'(req_ready), 32'(1 << (k % 3)));
      if (k > 0) chk($sformatf("cont_div_en_%0d", k), 32'(div_en), 32'h1);
      expq[k % 3].push_back(12'((200 + 30*k + (k % 3)) / ((k % 3) + 2)));
      cyc();
    end
    req_valid = '0;
    settle();
    chk("cont_div_en_last", 32'(div_en), 32'h1);
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid[i]) begin
          if (expq[i].size() == 0) begin
            chk($sformatf("cont_extra_rsp_%0d", i), 32'h1, 32'h0);
          end else begin
            v = expq[i].pop_front();
            chk($sformatf("cont_rsp_q_%0d", i), 32'(rsp_q[i*DW +: DW]), 32'(v));
          end
        end
      end
      cyc();
      settle();
    end
    for (int i = 0; i < NREQ; i++)
      chk($sformatf("cont_missing_%0d", i), 32'(expq[i].size()), 32'h0);

    // Backpressure on requester 0 plus simultaneous pop and issue.
    cyc();
    do_reset();
    rsp_ready = 3'b110;
    req_valid = 3'b001;
    req_dividend[0 +: DW] = 12'd50;
    req_divisor[0 +: QW]  = 8'd5;
    acc = 0;
    for (int n = 0; n < 24; n++) begin
      settle();
      if (req_ready[0]) acc++;
      cyc();
    end
    chk("bp_accepts", 32'(acc), 32'd4);
    req_valid = 3'b011;
    settle();
    chk("bp_other_ready", 32'(req_ready), 32'h2);
    chk("bp_rsp_valid0", 32'(rsp_valid[0]), 32'h1);
    cyc();
    req_valid = 3'b001;
    rsp_ready = 3'b111;
    settle();
    chk("bp_pop_cycle_ready", 32'(req_ready), 32'h0);
    chk("bp_rsp_q0", 32'(rsp_q[0 +: DW]), 32'd10);
    cyc();
    rsp_ready = 3'b110;
    acc = 0;
    for (int n = 0; n < 6; n++) begin
      settle();
      if (req_ready[0]) acc++;
      cyc();
    end
    chk("bp_one_more", 32'(acc), 32'd1);
    rsp_ready = 3'b111;
    settle();
    chk("sim_pop_no_credit", 32'(req_ready), 32'h0);
    cyc();
    settle();
    chk("sim_credit_before", 32'(dut.credit_q[0]), 32'd1);
    chk("sim_ready_issue", 32'(req_ready), 32'h1);
    cyc();
    rsp_ready = 3'b110;
    settle();
    chk("sim_credit_after", 32'(dut.credit_q[0]), 32'd1);
    chk("sim_ready_again", 32'(req_ready), 32'h1);
    cyc();
    settle();
    chk("sim_exhausted", 32'(req_ready), 32'h0);
    req_valid = '0;
    rsp_ready = 3'b111;
    acc = 0;
    while (busy && acc < 60) begin
      cyc();
      settle();
      acc++;
    end
    chk("bp_drain_busy", 32'(busy), 32'h0);

    // Divide by zero from requester 2.
    cyc();
    do_reset();
    rsp_ready = 3'b111;
    req_valid = 3'b100;
    req_dividend[2*DW +: DW] = 12'd55;
    req_divisor[2*QW +: QW]  = 8'd0;
    settle();
    chk("dz_ready", 32'(req_ready), 32'h4);
    cyc();
    req_valid = '0;
    settle();
    chk("dz_div_en", 32'(div_en), 32'h1);
    chk("dz_divisor", 32'(div_divisor), 32'h0);
    cyc(LAT);
    settle();
    chk("dz_rsp_early", 32'(rsp_valid), 32'h0);
    cyc();
    settle();
    chk("dz_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("dz_rsp_q", 32'(rsp_q[2*DW +: DW]), 32'hFFF);

    // Reset with five tags in flight.
    cyc();
    do_reset();
    rsp_ready = 3'b111;
    req_valid = 3'b111;
    cyc(5);
    req_valid = '0;
    rst = 1'b1;
    settle();
    chk("mid_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid_busy", 32'(busy), 32'h0);
    chk("mid_div_en", 32'(div_en), 32'h0);
    cyc();
    rst = 1'b0;
    stale = 1'b0;
    for (int n = 0; n < 20; n++) begin
      settle();
      if (rsp_valid != '0 || div_en || busy) stale = 1'b1;
      cyc();
    end
    chk("mid_no_stale", 32'(stale), 32'h0);
    req_valid = 3'b111;
    settle();
    chk("mid_first_grant", 32'(req_ready), 32'h1);
    cyc();
    req_valid = '0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
